// File: rtl/csa_pkg.sv
// rtl/csa_pkg.sv - shared sizing helpers and stage control record for the pipelined carry-select unit
package csa_pkg;

  function automatic int nblk(input int width, input int block);
    return width / block;
  endfunction

  function automatic int lat(input int width, input int block, input int bps);
    return (width / block) / bps;
  endfunction

  // Width-independent part of a stage record; data fields are added by the top.
  typedef struct packed {
    logic valid;
    logic carry;
    logic c_msb;
    logic sub;
  } stage_ctl_t;

endpackage

// File: rtl/csa_slice.sv
// rtl/csa_slice.sv - one carry-select slice: two ripple adders plus a carry-driven select
module csa_slice #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] s,
  output logic             cout,
  output logic             c_msb_in
);

  logic [BLOCK:0]   c0;
  logic [BLOCK:0]   c1;
  logic [BLOCK-1:0] s0;
  logic [BLOCK-1:0] s1;

  always_comb begin
    c0    = '0;
    c1    = '0;
    c1[0] = 1'b1;
    s0    = '0;
    s1    = '0;
    for (int i = 0; i < BLOCK; i++) begin
      s0[i]   = a[i] ^ b[i] ^ c0[i];
      c0[i+1] = (a[i] & b[i]) | (c0[i] & (a[i] ^ b[i]));
      s1[i]   = a[i] ^ b[i] ^ c1[i];
      c1[i+1] = (a[i] & b[i]) | (c1[i] & (a[i] ^ b[i]));
    end
  end

  // The incoming carry only drives mux selects, so the inter-slice path is mux-to-mux.
  assign s        = cin ? s1 : s0;
  assign cout     = cin ? c1[BLOCK] : c0[BLOCK];
  assign c_msb_in = cin ? c1[BLOCK-1] : c0[BLOCK-1];

endmodule

// File: rtl/pipelined_csa_unit.sv
// rtl/pipelined_csa_unit.sv - pipelined carry-select adder/subtractor with valid/ready backpressure
module pipelined_csa_unit
  import csa_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4,
  parameter int BPS   = 2
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf
);

  localparam int NBLK = nblk(WIDTH, BLOCK);
  localparam int LAT  = lat(WIDTH, BLOCK, BPS);
  localparam int SW   = BPS * BLOCK;

  if (WIDTH % BLOCK != 0) begin : g_bad_width
    $error("pipelined_csa_unit: WIDTH must be a multiple of BLOCK");
  end
  if (NBLK % BPS != 0) begin : g_bad_bps
    $error("pipelined_csa_unit: WIDTH/BLOCK must be a multiple of BPS");
  end

  typedef struct packed {
    stage_ctl_t       ctl;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
  } stage_t;

  stage_t           stg [LAT];
  stage_t           src [LAT];
  stage_t           nxt [LAT];
  logic [WIDTH-1:0] slice_sum;
  logic             slice_cout [NBLK];
  logic             slice_cmsb [NBLK];
  logic             stall;

  assign stall    = Out_valid && !Out_ready;
  assign In_ready = !stall;

  // B is inverted and the carry forced high at entry, so subtract needs no extra logic downstream.
  assign src[0] = {In_valid, (Sub ? 1'b1 : Cin), 1'b0, Sub, {WIDTH{1'b0}}, A, (Sub ? ~B : B)};

  for (genvar s = 0; s < LAT; s++) begin : g_stage
    localparam int LAST = (s + 1) * BPS - 1;
    localparam logic [WIDTH-1:0] MASK = ({WIDTH{1'b1}} >> (WIDTH - SW)) << (s * SW);

    if (s > 0) begin : g_src
      assign src[s] = stg[s-1];
    end

    for (genvar j = 0; j < BPS; j++) begin : g_slice
      localparam int G = s * BPS + j;
      logic cin;

      if (j == 0) begin : g_cin_reg
        assign cin = src[s].ctl.carry;
      end else begin : g_cin_chain
        assign cin = slice_cout[G-1];
      end

      csa_slice #(.BLOCK(BLOCK)) u_slice (
        .a        (src[s].a_rem[G*BLOCK +: BLOCK]),
        .b        (src[s].b_rem[G*BLOCK +: BLOCK]),
        .cin      (cin),
        .s        (slice_sum[G*BLOCK +: BLOCK]),
        .cout     (slice_cout[G]),
        .c_msb_in (slice_cmsb[G])
      );
    end

    assign nxt[s] = {src[s].ctl.valid, slice_cout[LAST], slice_cmsb[LAST], src[s].ctl.sub,
                     (src[s].sum & ~MASK) | (slice_sum & MASK), src[s].a_rem, src[s].b_rem};
  end

  // Bubbles advance with full beats; the only hold condition is a stalled output.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int k = 0; k < LAT; k++) stg[k] <= '0;
    end else if (!stall) begin
      for (int k = 0; k < LAT; k++) stg[k] <= nxt[k];
    end
  end

  assign Out_valid = stg[LAT-1].ctl.valid;
  assign Sum       = stg[LAT-1].sum;
  assign Cout      = stg[LAT-1].ctl.carry;
  assign Ovf       = stg[LAT-1].ctl.carry ^ stg[LAT-1].ctl.c_msb;

endmodule

// File: tb/tb_pipelined_csa_unit.sv
// tb/tb_pipelined_csa_unit.sv - scoreboard bench for the pipelined carry-select unit
module tb_pipelined_csa_unit;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          tag;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        In_valid, In_ready, Cin, Sub, Out_valid, Out_ready, Cout, Ovf;
  logic [15:0] A, B, Sum;

  logic        p_valid, p_cin, p_sub, p_oready;
  logic [31:0] p_a, p_b;
  logic [2:0]  p_ready, p_ov, p_cout, p_ovf;
  logic [31:0] p_sum [3];
  logic [7:0]  s8_sum;

  int   tests_run = 0;
  int   tests_failed = 0;
  int   en_cnt = 0;
  int   retired = 0;
  exp_t q[$];
  exp_t pq[3][$];
  exp_t none = '0;

  always #5 Clk = ~Clk;

  pipelined_csa_unit #(.WIDTH(16), .BLOCK(4), .BPS(2)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .In_valid(In_valid), .In_ready(In_ready), .A(A), .B(B),
    .Cin(Cin), .Sub(Sub), .Out_valid(Out_valid), .Out_ready(Out_ready), .Sum(Sum),
    .Cout(Cout), .Ovf(Ovf));

  pipelined_csa_unit #(.WIDTH(32), .BLOCK(4), .BPS(2)) dut_32_4_2 (
    .Clk(Clk), .Rst_n(Rst_n), .In_valid(p_valid), .In_ready(p_ready[0]), .A(p_a), .B(p_b),
    .Cin(p_cin), .Sub(p_sub), .Out_valid(p_ov[0]), .Out_ready(p_oready), .Sum(p_sum[0]),
    .Cout(p_cout[0]), .Ovf(p_ovf[0]));

  pipelined_csa_unit #(.WIDTH(32), .BLOCK(8), .BPS(4)) dut_32_8_4 (
    .Clk(Clk), .Rst_n(Rst_n), .In_valid(p_valid), .In_ready(p_ready[1]), .A(p_a), .B(p_b),
    .Cin(p_cin), .Sub(p_sub), .Out_valid(p_ov[1]), .Out_ready(p_oready), .Sum(p_sum[1]),
    .Cout(p_cout[1]), .Ovf(p_ovf[1]));

  pipelined_csa_unit #(.WIDTH(8), .BLOCK(2), .BPS(1)) dut_8_2_1 (
    .Clk(Clk), .Rst_n(Rst_n), .In_valid(p_valid), .In_ready(p_ready[2]), .A(p_a[7:0]),
    .B(p_b[7:0]), .Cin(p_cin), .Sub(p_sub), .Out_valid(p_ov[2]), .Out_ready(p_oready),
    .Sum(s8_sum), .Cout(p_cout[2]), .Ovf(p_ovf[2]));

  assign p_sum[2] = {24'd0, s8_sum};

  function automatic exp_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                 input logic cin, input logic sub);
    logic [63:0] m, aa, bb;
    logic [64:0] full;
    exp_t        e;
    m      = (64'd1 << w) - 64'd1;
    aa     = a & m;
    bb     = (sub ? ~b : b) & m;
    full   = {1'b0, aa} + {1'b0, bb} + {64'd0, sub | cin};
    e.sum  = full[63:0] & m;
    e.cout = full[w];
    e.ovf  = (aa[w-1] == bb[w-1]) && (e.sum[w-1] != aa[w-1]);
    e.tag  = 0;
    return e;
  endfunction

  // One clock of the 16-bit unit: retire/score the output beat, enqueue the accepted input beat.
  task automatic drive_cycle(input logic iv, input logic [15:0] a, input logic [15:0] b,
                             input logic cin, input logic sub, input logic ordy,
                             input exp_t e, output logic acc, output logic rdy);
    exp_t f;
    In_valid = iv; A = a; B = b; Cin = cin; Sub = sub; Out_ready = ordy;
    #1;
    rdy = In_ready;
    acc = iv && In_ready;
    if (Out_valid && Out_ready) begin
      tests_run++;
      if (q.size() == 0) begin
        tests_failed++;
        $display("FAIL spurious_beat: Out_valid=1 Sum=%h with no beat outstanding", Sum);
      end else begin
        f = q.pop_front();
        retired++;
        tests_run++;
        if ({Cout, Ovf, Sum} !== {f.cout, f.ovf, f.sum[15:0]}) begin
          tests_failed++;
          $display("FAIL result: got Sum=%h Cout=%b Ovf=%b, expected Sum=%h Cout=%b Ovf=%b",
                   Sum, Cout, Ovf, f.sum[15:0], f.cout, f.ovf);
        end
        tests_run++;
        if (en_cnt - f.tag !== 2) begin
          tests_failed++;
          $display("FAIL latency: got %0d enabled edges, expected 2", en_cnt - f.tag);
        end
      end
    end
    if (acc) begin
      f = e;
      f.tag = en_cnt;
      q.push_back(f);
    end
    @(posedge Clk);
    if (rdy) en_cnt++;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Rst_n = 1'b0; In_valid = 0; A = 0; B = 0; Cin = 0; Sub = 0; Out_ready = 1;
    p_valid = 0; p_a = 0; p_b = 0; p_cin = 0; p_sub = 0; p_oready = 1;
    repeat (3) @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    tests_run++;
    if ({Out_valid, Sum, Cout, Ovf} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got valid=%b Sum=%h Cout=%b Ovf=%b, expected all 0",
               Out_valid, Sum, Cout, Ovf);
    end
    tests_run++;
    if (In_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_in_ready: got %b, expected 1", In_ready);
    end
    tests_run++;
    if (p_ov !== 3'b000 || p_ready !== 3'b111) begin
      tests_failed++;
      $display("FAIL reset_param_units: got valid=%b ready=%b, expected 000/111", p_ov, p_ready);
    end
    @(negedge Clk);
  endtask

  task automatic test_directed();
    logic [15:0] va[5], vb[5], vs[5];
    logic        vc[5], vsub[5], vco[5], vov[5];
    logic        acc, rdy;
    exp_t        e;
    va  = '{16'h2AD5, 16'hFFFF, 16'hFFFF, 16'h0005, 16'h7FFF};
    vb  = '{16'h9E45, 16'hFFFF, 16'h0000, 16'h0007, 16'h0001};
    vc  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vsub = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vs  = '{16'hC91A, 16'hFFFF, 16'h0000, 16'hFFFE, 16'h8000};
    vco = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vov = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      e = '{sum: {48'd0, vs[i]}, cout: vco[i], ovf: vov[i], tag: 0};
      drive_cycle(1'b1, va[i], vb[i], vc[i], vsub[i], 1'b1, e, acc, rdy);
      if (i == 0) begin
        tests_run++;
        if (Out_valid !== 1'b0) begin
          tests_failed++;
          $display("FAIL first_beat_early: Out_valid=%b one edge after accept, expected 0", Out_valid);
        end
      end
    end
    repeat (4) drive_cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, none, acc, rdy);
    tests_run++;
    if (q.size() !== 0) begin
      tests_failed++;
      $display("FAIL directed_drain: %0d beats outstanding, expected 0", q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ba[8], bb[8];
    logic        bc[8], bs[8];
    logic        acc, rdy;
    int          idx, cyc, r0;
    for (int i = 0; i < 8; i++) begin
      ba[i] = 16'($urandom); bb[i] = 16'($urandom);
      bc[i] = 1'($urandom); bs[i] = (i % 3 == 1);
    end
    idx = 0; cyc = 0; r0 = retired;
    while (idx < 8 && cyc < 40) begin
      drive_cycle(1'b1, ba[idx], bb[idx], bc[idx], bs[idx], !(cyc >= 3 && cyc <= 5),
                  model(16, {48'd0, ba[idx]}, {48'd0, bb[idx]}, bc[idx], bs[idx]), acc, rdy);
      if (cyc >= 3 && cyc <= 5) begin
        tests_run++;
        if (rdy !== 1'b0) begin
          tests_failed++;
          $display("FAIL stall_in_ready: cycle %0d In_ready=%b, expected 0", cyc, rdy);
        end
      end
      if (acc) idx++;
      cyc++;
    end
    repeat (4) drive_cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, none, acc, rdy);
    tests_run++;
    if (retired - r0 !== 8 || q.size() !== 0) begin
      tests_failed++;
      $display("FAIL stream_count: retired %0d outstanding %0d, expected 8 and 0",
               retired - r0, q.size());
    end
  endtask

  task automatic test_reset_in_flight();
    logic acc, rdy;
    int   r0;
    drive_cycle(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1,
                model(16, 64'h1234, 64'h1111, 1'b0, 1'b0), acc, rdy);
    drive_cycle(1'b1, 16'h4321, 16'h0101, 1'b0, 1'b1, 1'b1,
                model(16, 64'h4321, 64'h0101, 1'b0, 1'b1), acc, rdy);
    In_valid = 1'b0;
    Rst_n = 1'b0;
    #1;
    tests_run++;
    if (Out_valid !== 1'b0 || Sum !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_flush: got valid=%b Sum=%h, expected 0/0000", Out_valid, Sum);
    end
    q.delete();
    @(negedge Clk);
    Rst_n = 1'b1;
    r0 = retired;
    repeat (5) drive_cycle(1'b0, 16'd0, 16'd0, 1'b0, 1'b0, 1'b1, none, acc, rdy);
    tests_run++;
    if (retired !== r0) begin
      tests_failed++;
      $display("FAIL stale_beat: %0d beats emerged after reset, expected 0", retired - r0);
    end
  endtask

  task automatic test_param_sweep();
    int   lats[3] = '{4, 1, 4};
    int   ws[3] = '{32, 32, 8};
    exp_t f;
    logic iv;
    for (int cyc = 0; cyc < 208; cyc++) begin
      iv = (cyc < 200) && ($urandom_range(0, 3) != 0);
      p_valid = iv; p_a = $urandom; p_b = $urandom;
      p_cin = 1'($urandom); p_sub = 1'($urandom);
      #1;
      for (int i = 0; i < 3; i++) begin
        if (p_ov[i]) begin
          tests_run++;
          if (pq[i].size() == 0) begin
            tests_failed++;
            $display("FAIL param%0d_spurious: cycle %0d Sum=%h", i, cyc, p_sum[i]);
          end else begin
            f = pq[i].pop_front();
            if ({p_sum[i], p_cout[i], p_ovf[i]} !== {f.sum[31:0], f.cout, f.ovf}
                || cyc - f.tag !== lats[i]) begin
              tests_failed++;
              $display("FAIL param%0d_result: got Sum=%h C=%b V=%b lat=%0d, expected Sum=%h C=%b V=%b lat=%0d",
                       i, p_sum[i], p_cout[i], p_ovf[i], cyc - f.tag,
                       f.sum[31:0], f.cout, f.ovf, lats[i]);
            end
          end
        end
      end
      if (iv) begin
        for (int i = 0; i < 3; i++) begin
          f = model(ws[i], {32'd0, p_a}, {32'd0, p_b}, p_cin, p_sub);
          f.tag = cyc;
          pq[i].push_back(f);
        end
      end
      @(posedge Clk);
      @(negedge Clk);
    end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (pq[i].size() !== 0) begin
        tests_failed++;
        $display("FAIL param%0d_drain: %0d beats never emerged", i, pq[i].size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_in_flight();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
